// File: rtl/bin_gray_pkg.sv
// Shared Gray-code helpers and defaults for the binary-to-Gray converter
// and its optional round-trip decoder.
package bin_gray_pkg;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic [31:0] bin2gray(logic [31:0] b, int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  // MSB-down prefix XOR: each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(logic [31:0] g, int w);
    logic [31:0] r;
    logic        acc;
    r   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        r[i] = acc;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder; bit i is the XOR reduction of
// every Gray bit from the MSB down to bit i.
module gray_to_bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/bin_to_gray.sv
// Binary to reflected-binary Gray converter with combinational and registered outputs.
// Define BIN2GRAY_ROUNDTRIP_EN to add a registered round-trip decode and sticky mismatch flag.
module bin_to_gray
  import bin_gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             bin_valid,
  output logic [WIDTH-1:0] gray_comb,
  output logic [WIDTH-1:0] gray_q,
  output logic             gray_valid,
  output logic [WIDTH-1:0] bin_rt,
  output logic             rt_err
);

  logic [WIDTH-1:0] code_q, code_d;
  logic             valid_q, valid_d;

  always_comb begin
    gray_comb = WIDTH'(bin2gray(32'(bin_in), WIDTH));
    code_d    = code_q;
    valid_d   = bin_valid;
    if (bin_valid) begin
      code_d = gray_comb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign gray_q     = code_q;
  assign gray_valid = valid_q;

`ifdef BIN2GRAY_ROUNDTRIP_EN
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic             chk_q, chk_d;
  logic             err_q, err_d;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (code_q),
    .bin  (dec_bin)
  );

  // src tracks the word behind code_q; ref delays it to line up with the decoded rt.
  always_comb begin
    src_d = bin_valid ? bin_in : src_q;
    rt_d  = dec_bin;
    ref_d = src_q;
    chk_d = valid_q;
    err_d = err_q | (chk_q && (rt_q != ref_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      ref_q <= '0;
      rt_q  <= '0;
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      src_q <= src_d;
      ref_q <= ref_d;
      rt_q  <= rt_d;
      chk_q <= chk_d;
      err_q <= err_d;
    end
  end

  assign bin_rt = rt_q;
  assign rt_err = err_q;
`else
  assign bin_rt = '0;
  assign rt_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Directed bench for bin_to_gray at WIDTH 8, 16 and 1; round-trip checks
// follow BIN2GRAY_ROUNDTRIP_EN.
module tb_bin_to_gray;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bin_in = '0;
  logic        bin_valid = 1'b0;
  logic [7:0]  gray_comb, gray_q, bin_rt;
  logic        gray_valid, rt_err;

  logic [15:0] bin16 = '0;
  logic        valid16 = 1'b0;
  logic [15:0] gray_comb16, gray_q16, bin_rt16;
  logic        gray_valid16, rt_err16;

  logic [0:0]  bin1 = '0;
  logic        valid1 = 1'b0;
  logic [0:0]  gray_comb1, gray_q1, bin_rt1;
  logic        gray_valid1, rt_err1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bin_to_gray #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .gray_comb(gray_comb), .gray_q(gray_q), .gray_valid(gray_valid),
    .bin_rt(bin_rt), .rt_err(rt_err)
  );

  bin_to_gray #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .bin_in(bin16), .bin_valid(valid16),
    .gray_comb(gray_comb16), .gray_q(gray_q16), .gray_valid(gray_valid16),
    .bin_rt(bin_rt16), .rt_err(rt_err16)
  );

  bin_to_gray #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .bin_in(bin1), .bin_valid(valid1),
    .gray_comb(gray_comb1), .gray_q(gray_q1), .gray_valid(gray_valid1),
    .bin_rt(bin_rt1), .rt_err(rt_err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bin_in = 8'h05; bin_valid = 1'b1;
    tick(); tick();
    tests_run++;
    if (gray_q !== 8'h00) begin tests_failed++; $display("FAIL reset_gray_q got=%02h want=00", gray_q); end
    tests_run++;
    if (gray_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_gray_valid got=%b want=0", gray_valid); end
    tests_run++;
    if (bin_rt !== 8'h00) begin tests_failed++; $display("FAIL reset_bin_rt got=%02h want=00", bin_rt); end
    tests_run++;
    if (rt_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rt_err got=%b want=0", rt_err); end
    tests_run++;
    if (gray_comb !== 8'h07) begin tests_failed++; $display("FAIL reset_comb got=%02h want=07", gray_comb); end
    tests_run++;
    if (gray_q16 !== 16'h0000 || gray_q1 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wide got16=%04h got1=%b want=0", gray_q16, gray_q1);
    end
    $display("[TB] reset: gray_q=%02h gray_valid=%b comb(05)=%02h", gray_q, gray_valid, gray_comb);
    rst = 1'b0; bin_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_g;
    for (int i = 0; i < 256; i++) begin
      bin_in = 8'(i); bin_valid = 1'b1;
      exp_g = 8'(i ^ (i >> 1));
      #1;
      tests_run++;
      if (gray_comb !== exp_g) begin tests_failed++; $display("FAIL sweep_comb bin=%02h got=%02h want=%02h", i, gray_comb, exp_g); end
      tick();
      tests_run++;
      if (gray_q !== exp_g || gray_valid !== 1'b1) begin
        tests_failed++; $display("FAIL sweep_reg bin=%02h got=%02h/%b want=%02h/1", i, gray_q, gray_valid, exp_g);
      end
`ifdef BIN2GRAY_ROUNDTRIP_EN
      if (i > 0) begin
        tests_run++;
        if (bin_rt !== 8'(i - 1)) begin tests_failed++; $display("FAIL sweep_rt bin=%02h got=%02h want=%02h", i, bin_rt, 8'(i - 1)); end
      end
      tests_run++;
      if (rt_err !== 1'b0) begin tests_failed++; $display("FAIL sweep_rt_err bin=%02h got=%b want=0", i, rt_err); end
`endif
      $display("[TB] sweep bin=%02h gray_q=%02h", i, gray_q);
    end
    bin_valid = 1'b0;
    // Hand-computed anchors
    bin_in = 8'h05; #1;
    tests_run++;
    if (gray_comb !== 8'h07) begin tests_failed++; $display("FAIL anchor_05 got=%02h want=07", gray_comb); end
    bin_in = 8'h80; #1;
    tests_run++;
    if (gray_comb !== 8'hC0) begin tests_failed++; $display("FAIL anchor_80 got=%02h want=C0", gray_comb); end
    bin_in = 8'hFF; #1;
    tests_run++;
    if (gray_comb !== 8'h80) begin tests_failed++; $display("FAIL anchor_FF got=%02h want=80", gray_comb); end
  endtask

  task automatic test_adjacency();
    logic [7:0] a, b;
    for (int i = 0; i < 256; i++) begin
      bin_in = 8'(i); #1; a = gray_comb;
      bin_in = 8'((i + 1) % 256); #1; b = gray_comb;
      tests_run++;
      if ($countones(a ^ b) != 1) begin
        tests_failed++; $display("FAIL adjacency bin=%02h gray=%02h next=%02h", i, a, b);
      end
      $display("[TB] adjacency %02h->%02h", a, b);
    end
  endtask

  task automatic test_valid_gating();
    tick();
    bin_in = 8'h0A; bin_valid = 1'b1;
    tick();
    tests_run++;
    if (gray_q !== 8'h0F || gray_valid !== 1'b1) begin
      tests_failed++; $display("FAIL gate_load got=%02h/%b want=0F/1", gray_q, gray_valid);
    end
    bin_in = 8'h33; bin_valid = 1'b0; #1;
    tests_run++;
    if (gray_comb !== 8'h2A) begin tests_failed++; $display("FAIL gate_comb got=%02h want=2A", gray_comb); end
    tick();
    tests_run++;
    if (gray_q !== 8'h0F || gray_valid !== 1'b0) begin
      tests_failed++; $display("FAIL gate_hold got=%02h/%b want=0F/0", gray_q, gray_valid);
    end
    $display("[TB] gating: gray_q=%02h gray_valid=%b", gray_q, gray_valid);
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (gray_q !== 8'h00 || gray_valid !== 1'b0) begin
      tests_failed++; $display("FAIL async_rst got=%02h/%b want=00/0", gray_q, gray_valid);
    end
    tests_run++;
    if (bin_rt !== 8'h00 || rt_err !== 1'b0) begin
      tests_failed++; $display("FAIL async_rst_rt got=%02h/%b want=00/0", bin_rt, rt_err);
    end
    bin_in = 8'h55; bin_valid = 1'b1;
    tick();
    tests_run++;
    if (gray_q !== 8'h00 || gray_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_hold got=%02h/%b want=00/0", gray_q, gray_valid);
    end
    rst = 1'b0; bin_in = 8'h01; bin_valid = 1'b1;
    tick();
    tests_run++;
    if (gray_q !== 8'h01 || gray_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rst_release got=%02h/%b want=01/1", gray_q, gray_valid);
    end
    bin_valid = 1'b0;
    $display("[TB] async reset: released, gray_q=%02h", gray_q);
  endtask

  task automatic test_roundtrip();
`ifdef BIN2GRAY_ROUNDTRIP_EN
    bin_in = 8'h10; bin_valid = 1'b1;
    tick(); tick();
    tests_run++;
    if (bin_rt !== 8'h10 || rt_err !== 1'b0) begin
      tests_failed++; $display("FAIL rt_clean got=%02h/%b want=10/0", bin_rt, rt_err);
    end
    force dut.code_q = 8'h19;
    tick();
    release dut.code_q;
    tests_run++;
    if (rt_err !== 1'b0) begin tests_failed++; $display("FAIL rt_early got=%b want=0", rt_err); end
    tick();
    tests_run++;
    if (rt_err !== 1'b1) begin tests_failed++; $display("FAIL rt_err_set got=%b want=1", rt_err); end
    bin_valid = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (rt_err !== 1'b1) begin tests_failed++; $display("FAIL rt_err_sticky got=%b want=1", rt_err); end
    rst = 1'b1; #1;
    tests_run++;
    if (rt_err !== 1'b0) begin tests_failed++; $display("FAIL rt_err_clear got=%b want=0", rt_err); end
    tick();
    rst = 1'b0;
    $display("[TB] roundtrip: injected flip, rt_err cleared by reset");
`else
    bin_in = 8'h3C; bin_valid = 1'b1;
    tick(); tick();
    bin_valid = 1'b0;
    tests_run++;
    if (bin_rt !== 8'h00 || rt_err !== 1'b0) begin
      tests_failed++; $display("FAIL rt_tied got=%02h/%b want=00/0", bin_rt, rt_err);
    end
    $display("[TB] roundtrip disabled: bin_rt=%02h rt_err=%b", bin_rt, rt_err);
`endif
  endtask

  task automatic test_widths();
    bin16 = 16'h1234; valid16 = 1'b1; bin1 = 1'b1; valid1 = 1'b1; #1;
    tests_run++;
    if (gray_comb16 !== 16'h1B2E || gray_comb1 !== 1'b1) begin
      tests_failed++; $display("FAIL width_comb_a got16=%04h got1=%b want=1B2E/1", gray_comb16, gray_comb1);
    end
    tick();
    tests_run++;
    if (gray_q16 !== 16'h1B2E || gray_q1 !== 1'b1 || gray_valid16 !== 1'b1 || gray_valid1 !== 1'b1) begin
      tests_failed++; $display("FAIL width_reg_a got16=%04h got1=%b want=1B2E/1", gray_q16, gray_q1);
    end
    bin16 = 16'hFFFF; bin1 = 1'b0; #1;
    tests_run++;
    if (gray_comb16 !== 16'h8000 || gray_comb1 !== 1'b0) begin
      tests_failed++; $display("FAIL width_comb_b got16=%04h got1=%b want=8000/0", gray_comb16, gray_comb1);
    end
    tick();
    tests_run++;
    if (gray_q16 !== 16'h8000 || gray_q1 !== 1'b0) begin
      tests_failed++; $display("FAIL width_reg_b got16=%04h got1=%b want=8000/0", gray_q16, gray_q1);
    end
`ifdef BIN2GRAY_ROUNDTRIP_EN
    tests_run++;
    if (bin_rt16 !== 16'h1234 || bin_rt1 !== 1'b1 || rt_err16 !== 1'b0 || rt_err1 !== 1'b0) begin
      tests_failed++; $display("FAIL width_rt got16=%04h got1=%b want=1234/1", bin_rt16, bin_rt1);
    end
`else
    tests_run++;
    if (bin_rt16 !== 16'h0000 || bin_rt1 !== 1'b0 || rt_err16 !== 1'b0 || rt_err1 !== 1'b0) begin
      tests_failed++; $display("FAIL width_rt got16=%04h got1=%b want=0000/0", bin_rt16, bin_rt1);
    end
`endif
    valid16 = 1'b0; valid1 = 1'b0;
    $display("[TB] widths: gray16=%04h gray1=%b", gray_q16, gray_q1);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_adjacency();
    test_valid_gating();
    test_async_reset();
    test_roundtrip();
    test_widths();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
